// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared constants and state encoding for the modular multiplier
package ecc_pkg;

  localparam int MOD_MUL_LEN = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mod_mul_state_e;

endpackage

// File: rtl/mod_mul_step.sv
// rtl/mod_mul_step.sv - one MSB-first interleaved step: r' = (2r + bit*a) mod p
module mod_mul_step
  import ecc_pkg::*;
#(
  parameter int LEN = MOD_MUL_LEN
) (
  input  logic [LEN-1:0] r_i,
  input  logic [LEN-1:0] a_i,
  input  logic [LEN-1:0] p_i,
  input  logic           bit_i,
  output logic [LEN-1:0] r_o
);

  logic [LEN:0]   p_ext;
  logic [LEN:0]   dbl;
  logic [LEN-1:0] dbl_red;
  logic [LEN:0]   sum;
  logic [LEN-1:0] sum_red;

  // With r,a < p each intermediate is < 2p, so one subtraction reduces fully;
  // the LEN-bit wrap-around subtraction is exact because the result is < p.
  always_comb begin
    p_ext   = {1'b0, p_i};
    dbl     = {r_i, 1'b0};
    dbl_red = (dbl >= p_ext) ? (dbl[LEN-1:0] - p_i) : dbl[LEN-1:0];
    sum     = {1'b0, dbl_red} + {1'b0, a_i};
    sum_red = (sum >= p_ext) ? (sum[LEN-1:0] - p_i) : sum[LEN-1:0];
    r_o     = bit_i ? sum_red : dbl_red;
  end

endmodule

// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - bit-serial modular multiplier c = (a*b) mod p, one bit of b per cycle
module mod_mul
  import ecc_pkg::*;
#(
  parameter int LEN = MOD_MUL_LEN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic [LEN-1:0] p,
  output logic [LEN-1:0] c,
  output logic           busy,
  output logic           done
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  mod_mul_state_e state_q;
  logic [LEN-1:0] a_q;
  logic [LEN-1:0] b_q;
  logic [LEN-1:0] p_q;
  logic [LEN-1:0] r_q;
  logic [LEN-1:0] r_d;
  logic [CW-1:0]  cnt_q;

  mod_mul_step #(.LEN(LEN)) u_step (
    .r_i   (r_q),
    .a_i   (a_q),
    .p_i   (p_q),
    .bit_i (b_q[cnt_q]),
    .r_o   (r_d)
  );

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      c       <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            p_q     <= p;
            r_q     <= '0;
            cnt_q   <= CW'(LEN - 1);
            state_q <= RUN;
          end
        end
        RUN: begin
          r_q <= r_d;
          // Counter alone bounds the run, so bad operands cannot stall the FSM.
          if (cnt_q == '0) begin
            state_q <= FIN;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        FIN: begin
          c       <= r_q;
          done    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul.sv
// tb/tb_mod_mul.sv - directed and reference-model checks for mod_mul at LEN=8 and LEN=256
module tb_mod_mul;

  localparam logic [255:0] P256 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic         clk = 1'b0;
  logic         rst;
  logic         start8;
  logic [7:0]   a8, b8, p8, c8;
  logic         busy8, done8;
  logic         start256;
  logic [255:0] a256, b256, p256, c256;
  logic         busy256, done256;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod_mul #(.LEN(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .p     (p8),
    .c     (c8),
    .busy  (busy8),
    .done  (done8)
  );

  mod_mul #(.LEN(256)) dut256 (
    .clk   (clk),
    .rst   (rst),
    .start (start256),
    .a     (a256),
    .b     (b256),
    .p     (p256),
    .c     (c256),
    .busy  (busy256),
    .done  (done256)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                     input logic [7:0] exp);
    int lat;
    lat = 0;
    a8 = aa;
    b8 = bb;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check({tag, "_busy"}, 256'(busy8), 256'(1));
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (done8) lat = k;
    end
    check({tag, "_lat"}, 256'(lat), 256'(9));
    check({tag, "_c"}, 256'(c8), 256'(exp));
    tick();
    check({tag, "_done_once"}, 256'(done8), 256'(0));
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    if (v >= P256) v = v - P256;
    return v;
  endfunction

  function automatic logic [255:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] prod;
    prod = {256'b0, x} * {256'b0, y};
    return 256'(prod % {256'b0, P256});
  endfunction

  initial begin
    int ndone;
    int lat;
    logic [255:0] exp256;

    rst = 1'b1;
    start8 = 1'b0;
    start256 = 1'b0;
    a8 = '0; b8 = '0; p8 = 8'd251;
    a256 = '0; b256 = '0; p256 = P256;
    tick();
    tick();
    rst = 1'b0;
    check("rst_c8", 256'(c8), 256'(0));
    check("rst_busy8", 256'(busy8), 256'(0));
    check("rst_done8", 256'(done8), 256'(0));
    check("rst_c256", c256, 256'(0));
    check("rst_busy256", 256'(busy256), 256'(0));

    op8("m3x5", 8'd3, 8'd5, 8'd15);
    op8("m250x250", 8'd250, 8'd250, 8'd1);
    op8("inv2x126", 8'd2, 8'd126, 8'd1);
    op8("m0x77", 8'd0, 8'd77, 8'd0);
    op8("m250x2", 8'd250, 8'd2, 8'd249);
    op8("m77x1", 8'd77, 8'd1, 8'd77);

    // restart attempt mid-run must be dropped
    a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done8) ndone++;
    end
    check("repulse_ndone", 256'(ndone), 256'(1));
    check("repulse_c", 256'(c8), 256'(15));
    check("repulse_busy", 256'(busy8), 256'(0));

    // reset four cycles into RUN
    a8 = 8'd250; b8 = 8'd2; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 256'(busy8), 256'(0));
    check("abort_c", 256'(c8), 256'(0));
    check("abort_done", 256'(done8), 256'(0));
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done8) ndone++;
    end
    check("abort_no_done", 256'(ndone), 256'(0));
    op8("after_abort", 8'd250, 8'd2, 8'd249);

    rst = 1'b1; start8 = 1'b1;
    tick();
    rst = 1'b0; start8 = 1'b0;
    check("rst_over_start", 256'(busy8), 256'(0));

    // LEN=256 random operands, each start issued in the done cycle of the previous
    a256 = P256 - 256'd1;
    b256 = P256 - 256'd1;
    exp256 = ref_mul(a256, b256);
    start256 = 1'b1;
    tick();
    start256 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      lat = 0;
      for (int k = 1; k <= 400 && lat == 0; k++) begin
        tick();
        if (done256) lat = k;
      end
      check($sformatf("r256_lat_%0d", i), 256'(lat), 256'(257));
      check($sformatf("r256_c_%0d", i), c256, exp256);
      if (i < 99) begin
        a256 = rnd256();
        b256 = rnd256();
        exp256 = ref_mul(a256, b256);
        start256 = 1'b1;
        tick();
        start256 = 1'b0;
        check($sformatf("r256_b2b_%0d", i), 256'(busy256), 256'(1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
